// File: rtl/awgn_pkg.sv
// Shared types and constants for the Gilbert-Elliott burst-noise channel.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package awgn_pkg;

    typedef enum logic {
        GOOD = 1'b0,
        BAD  = 1'b1
    } ch_state_t;

    localparam int          GAIN_FRAC = 7;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    // 128 * 10^(-snr/20), rounded; index is SNR in dB.
    localparam logic [7:0] GAIN_LUT [16] = '{
        8'd128, 8'd114, 8'd102, 8'd91, 8'd81, 8'd72, 8'd64, 8'd57,
        8'd51,  8'd45,  8'd40,  8'd36, 8'd32, 8'd29, 8'd26, 8'd23
    };

endpackage

// File: rtl/noise_lfsr.sv
// 32-bit Galois LFSR advanced 32 positions per enabled cycle.
// Latency: new word visible the cycle after en.
// Backpressure: none; holds its word while en=0.
module noise_lfsr
    import awgn_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] rnd
);

    // An all-zero state would lock the register up.
    localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] rnd_nxt;

    always_comb begin
        rnd_nxt = rnd;
        for (int i = 0; i < 32; i++) begin
            rnd_nxt = {1'b0, rnd_nxt[31:1]} ^ (rnd_nxt[0] ? LFSR_MASK : 32'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rnd <= SEED_NZ;
        end else if (en) begin
            rnd <= rnd_nxt;
        end
    end

endmodule

// File: rtl/ge_noise_channel.sv
// Gilbert-Elliott burst-noise channel; output wraps unless AWGN_SAT_EN is defined (then clamps).
// Latency: 3 cycles in_valid -> out_valid, 1 sample/cycle.
// Backpressure: none; in_valid gaps propagate as out_valid gaps.
module ge_noise_channel
    import awgn_pkg::*;
#(
    parameter int          DATA_W      = 16,
    parameter int          NOISE_W     = 6,
    parameter int          N_SUM       = 4,
    parameter int          NOISE_SHIFT = 4,
    parameter logic [31:0] SEED        = 32'hACE1_2024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        snr_good,
    input  logic [3:0]        snr_bad,
    input  logic [7:0]        p_gb,
    input  logic [7:0]        p_bg,
    input  logic              bypass,
    input  logic              clear_stats,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              ch_state,
    output logic [31:0]       bad_count
);

    localparam int GW = NOISE_W + $clog2(N_SUM) + 1;
    localparam int PW = GW + 9;
    localparam int SW = DATA_W + 2;

    if (N_SUM * NOISE_W + 8 > 32) begin : g_cfg_check
        $error("ge_noise_channel: N_SUM*NOISE_W + 8 must not exceed 32");
    end

    logic [31:0] rnd;

    noise_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (in_valid),
        .rnd   (rnd)
    );

    // Gaussian approximation and transition draw from the current word.
    logic [GW-1:0]        u_sum;
    logic signed [GW-1:0] g_val;
    logic [7:0]           draw;

    always_comb begin
        u_sum = '0;
        for (int k = 0; k < N_SUM; k++) begin
            u_sum = u_sum + GW'(rnd[k*NOISE_W +: NOISE_W]);
        end
    end

    assign g_val = $signed(u_sum - GW'(N_SUM * (2 ** (NOISE_W - 1))));
    assign draw  = rnd[31:24];

    // Channel state: the pre-update state labels the accepted sample.
    ch_state_t st, st_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= GOOD;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        if (in_valid) begin
            case (st)
                GOOD:    if (draw < p_gb) st_nxt = BAD;
                BAD:     if (draw < p_bg) st_nxt = GOOD;
                default: st_nxt = GOOD;
            endcase
        end
    end

    // Bypass is folded into a zero gain so noise is exactly 0 downstream.
    logic [3:0] snr_sel;
    logic [7:0] gain_sel;

    assign snr_sel  = (st == BAD) ? snr_bad : snr_good;
    assign gain_sel = bypass ? 8'd0 : GAIN_LUT[snr_sel];

    // Stage 1: sample, g, state, gain.
    logic                     s1_vld;
    logic signed [DATA_W-1:0] s1_data;
    logic signed [GW-1:0]     s1_g;
    ch_state_t                s1_st;
    logic [7:0]               s1_gain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_g    <= '0;
            s1_st   <= GOOD;
            s1_gain <= '0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_data <= $signed(in_data);
                s1_g    <= g_val;
                s1_st   <= st;
                s1_gain <= gain_sel;
            end
        end
    end

    // Stage 2: signed product of g and the unsigned gain.
    logic                     s2_vld;
    logic signed [DATA_W-1:0] s2_data;
    logic signed [PW-1:0]     s2_prod;
    ch_state_t                s2_st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_vld  <= 1'b0;
            s2_data <= '0;
            s2_prod <= '0;
            s2_st   <= GOOD;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_data <= s1_data;
                s2_prod <= s1_g * $signed({1'b0, s1_gain});
                s2_st   <= s1_st;
            end
        end
    end

    // Stage 3: scale, add at DATA_W+2 bits, resolve overflow.
    logic signed [PW-1:0]     scaled;
    logic signed [SW-1:0]     noise;
    logic signed [SW-1:0]     sum;
    logic signed [DATA_W-1:0] res;

    assign scaled = s2_prod >>> GAIN_FRAC;
    assign noise  = SW'(scaled) <<< NOISE_SHIFT;
    assign sum    = SW'(s2_data) + noise;

`ifdef AWGN_SAT_EN
    always_comb begin
        res = sum[DATA_W-1:0];
        if (sum[SW-1:DATA_W-1] != {(SW-DATA_W+1){sum[SW-1]}}) begin
            res = sum[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign res = sum[DATA_W-1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            ch_state  <= 1'b0;
        end else begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_data <= res;
                ch_state <= s2_st;
            end
        end
    end

    // A BAD sample is counted as it leaves the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_count <= '0;
        end else if (clear_stats) begin
            bad_count <= '0;
        end else if (out_valid && ch_state && (bad_count != 32'hFFFF_FFFF)) begin
            bad_count <= bad_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_ge_noise_channel.sv
// Randomised bench for ge_noise_channel against a sample-level reference model.
`timescale 1ns/1ps
module tb_ge_noise_channel;

    localparam logic [31:0] SEED_V = 32'hACE1_2024;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic [3:0]  snr_good, snr_bad;
    logic [7:0]  p_gb, p_bg;
    logic        bypass, clear_stats;
    logic        out_valid;
    logic [15:0] out_data;
    logic        ch_state;
    logic [31:0] bad_count;

    ge_noise_channel dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .snr_good    (snr_good),
        .snr_bad     (snr_bad),
        .p_gb        (p_gb),
        .p_bg        (p_bg),
        .bypass      (bypass),
        .clear_stats (clear_stats),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .ch_state    (ch_state),
        .bad_count   (bad_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int gain_tab [16] = '{128, 114, 102, 91, 81, 72, 64, 57, 51, 45, 40, 36, 32, 29, 26, 23};

    function automatic logic [31:0] step1(input logic [31:0] w);
        return w[0] ? ((w >> 1) ^ 32'h8020_0003) : (w >> 1);
    endfunction

    function automatic logic [31:0] step32(input logic [31:0] w);
        logic [31:0] r = w;
        for (int i = 0; i < 32; i++) r = step1(r);
        return r;
    endfunction

    function automatic int g_of(input logic [31:0] w);
        int s = 0;
        for (int k = 0; k < 4; k++) s += int'(w[k*6 +: 6]);
        return s - 128;
    endfunction

    function automatic int noise_of(input int g, input int gain);
        int p = g * gain;
        return (p >>> 7) * 16;
    endfunction

    function automatic logic [15:0] resolve(input int v);
`ifdef AWGN_SAT_EN
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return 16'(v);
    endfunction

    typedef struct {
        int          due;
        logic [15:0] dat;
        logic        st;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_lfsr = SEED_V;
    logic        m_st   = 1'b0;
    logic [15:0] h_dat  = '0;
    logic        h_st   = 1'b0;
    logic [31:0] m_bc   = '0;

    longint st_sum;
    int     st_maxabs, st_neg, st_badexp, st_nout;

    task automatic stat_reset();
        st_sum = 0; st_maxabs = 0; st_neg = 0; st_badexp = 0; st_nout = 0;
    endtask

    // Compare process: every cycle, away from the active edge.
    initial begin
        logic ev;
        int   dv;
        forever begin
            @(negedge clk);
            ev = 1'b0;
            if (q.size() > 0 && q[0].due == edge_n) begin
                ev    = 1'b1;
                h_dat = q[0].dat;
                h_st  = q[0].st;
                void'(q.pop_front());
            end
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("out_data", 32'(out_data), 32'(h_dat));
            chk("ch_state", 32'(ch_state), 32'(h_st));
            chk("bad_count", bad_count, m_bc);
            if (ev) begin
                dv = int'($signed(out_data));
                st_sum += dv;
                st_nout++;
                if (dv < 0) st_neg++;
                if ((dv < 0 ? -dv : dv) > st_maxabs) st_maxabs = (dv < 0 ? -dv : dv);
                if (h_st) st_badexp++;
            end
            if (clear_stats) m_bc = '0;
            else if (ev && h_st && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
        end
    end

    // Present one input cycle; config inputs set by the caller apply to it.
    task automatic drive(input logic v, input logic [15:0] dat);
        exp_t        e;
        logic [31:0] w;
        logic [7:0]  d;
        int          gn;
        in_valid = v;
        in_data  = dat;
        if (v) begin
            w  = m_lfsr;
            d  = w[31:24];
            gn = bypass ? 0 : gain_tab[m_st ? snr_bad : snr_good];
            e.due = edge_n + 3;
            e.dat = resolve(int'($signed(dat)) + noise_of(g_of(w), gn));
            e.st  = m_st;
            q.push_back(e);
            if (!m_st && d < p_gb)     m_st = 1'b1;
            else if (m_st && d < p_bg) m_st = 1'b0;
            m_lfsr = step32(w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; clear_stats = 1'b0;
        q.delete();
        m_lfsr = SEED_V; m_st = 1'b0; h_dat = '0; h_st = 1'b0; m_bc = '0;
        #1;
        chk("reset_drops_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic        pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] rdat [10];

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        snr_good = '0; snr_bad = '0; p_gb = '0; p_bg = '0;
        bypass = 1'b0; clear_stats = 1'b0;
        stat_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_ch_state", 32'(ch_state), 32'd0);
        chk("rst_bad_count", bad_count, 32'd0);

        // Hand-computed pins on the model itself.
        chk("pin_step1_1", step1(32'd1), 32'h8020_0003);
        chk("pin_step1_2", step1(32'd2), 32'd1);
        chk("pin_g_zero", 32'(g_of(32'd0)), 32'(-128));
        chk("pin_g_ones", 32'(g_of(32'hFFFF_FFFF)), 32'd124);
        chk("pin_g_41", 32'(g_of(32'h41)), 32'(-126));
        chk("pin_n_min", 32'(noise_of(-128, 128)), 32'(-2048));
        chk("pin_n_floor", 32'(noise_of(124, 23)), 32'd352);
        chk("pin_n_neg", 32'(noise_of(-1, 23)), 32'(-16));
`ifdef AWGN_SAT_EN
        chk("pin_resolve", 32'(resolve(32767 + 16)), 32'h7FFF);
`else
        chk("pin_resolve", 32'(resolve(32767 + 16)), 32'h800F);
`endif
        reset = 1'b0;

        // Bypass ramp.
        bypass = 1'b1; snr_good = 4'd9;
        for (int i = 0; i < 100; i++) drive(1'b1, 16'(i));
        repeat (5) drive(1'b0, 16'd0);
        chk("bypass_last", 32'(out_data), 32'd99);
        chk("bypass_bc", bad_count, 32'd0);
        chk("bypass_state", 32'(ch_state), 32'd0);

        // Stream gaps.
        bypass = 1'b0; snr_good = 4'd3; snr_bad = 4'd1; p_gb = 8'd40; p_bg = 8'd80;
        for (int k = 0; k < 5; k++) drive(pat[k], 16'($urandom));
        repeat (5) drive(1'b0, 16'd0);

        // Forced BAD at full scale.
        p_gb = 8'd255; p_bg = 8'd0; snr_bad = 4'd0; snr_good = 4'd0;
        clear_stats = 1'b1;
        drive(1'b0, 16'd0);
        clear_stats = 1'b0;
        stat_reset();
        for (int i = 0; i < 200; i++) drive(1'b1, 16'h7FFF);
        repeat (5) drive(1'b0, 16'd0);
        chk("bad_track", bad_count, 32'(st_badexp));
        chk("forced_bad_state", 32'(ch_state), 32'd1);
`ifdef AWGN_SAT_EN
        chk("sat_never_neg", 32'(st_neg), 32'd0);
`else
        chk("wrap_seen", 32'(st_neg > 0), 32'd1);
`endif
        // clear_stats coincides with the final BAD output.
        for (int i = 0; i < 20; i++) drive(1'b1, 16'h7FFF);
        drive(1'b0, 16'd0);
        drive(1'b0, 16'd0);
        clear_stats = 1'b1;
        drive(1'b0, 16'd0);
        clear_stats = 1'b0;
        repeat (3) drive(1'b0, 16'd0);
        chk("clear_beats_inc", bad_count, 32'd0);

        // Statistics. Slices average 31.5, so the mean noise is -0.5*N_SUM*16 = -32.
        do_reset();
        p_gb = 8'd0; p_bg = 8'd0; snr_good = 4'd0; bypass = 1'b0;
        stat_reset();
        for (int i = 0; i < 4096; i++) drive(1'b1, 16'd0);
        repeat (5) drive(1'b0, 16'd0);
        chk("stat_count", 32'(st_nout), 32'd4096);
        chk("stat_mean", 32'(st_sum >= -80 * 4096 && st_sum <= 16 * 4096), 32'd1);
        chk("stat_maxabs", 32'(st_maxabs <= 2048), 32'd1);

        // Reset mid-stream, then replay.
        do_reset();
        p_gb = 8'd64; p_bg = 8'd64; snr_good = 4'd7; snr_bad = 4'd1;
        for (int i = 0; i < 10; i++) rdat[i] = 16'($urandom);
        for (int i = 0; i < 10; i++) drive(1'b1, rdat[i]);
        do_reset();
        for (int i = 0; i < 10; i++) drive(1'b1, rdat[i]);
        repeat (5) drive(1'b0, 16'd0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            snr_good    = 4'($urandom_range(15));
            snr_bad     = 4'($urandom_range(15));
            p_gb        = 8'($urandom);
            p_bg        = 8'($urandom);
            bypass      = ($urandom_range(9) == 0);
            clear_stats = ($urandom_range(29) == 0);
            drive($urandom_range(3) != 0, 16'($urandom));
        end
        clear_stats = 1'b0;
        repeat (5) drive(1'b0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
